// File: rtl/reg_wb_ctrl_if.sv
// Issue, hazard-query and register-file write bundle for the writeback controller.
// Latency: none, this file only groups the signals.
// Backpressure: iss_rdy_* is driven by the slave and the master holds a rejected request.
interface reg_wb_ctrl_if;
    // even pipe issue
    logic         iss_vld_ep;
    logic [6:0]   iss_rt_ep;
    logic [127:0] iss_data_ep;
    logic [2:0]   iss_lat_ep;
    logic         iss_rdy_ep;
    logic         iss_err_ep;
    // odd pipe issue
    logic         iss_vld_op;
    logic [6:0]   iss_rt_op;
    logic [127:0] iss_data_op;
    logic [2:0]   iss_lat_op;
    logic         iss_rdy_op;
    logic         iss_err_op;
    // global clear
    logic         flush;
    // hazard queries
    logic [6:0]   chk_addr_a;
    logic [6:0]   chk_addr_b;
    logic         chk_hit_a;
    logic         chk_hit_b;
    // register file write ports
    logic         rt_wr_en_ep;
    logic [6:0]   rt_addr_ep;
    logic [127:0] rt_wr_ep;
    logic         rt_wr_en_op;
    logic [6:0]   rt_addr_op;
    logic [127:0] rt_wr_op;
    // occupancy
    logic [2:0]   pend_cnt_ep;
    logic [2:0]   pend_cnt_op;

    modport master (
        output iss_vld_ep, iss_rt_ep, iss_data_ep, iss_lat_ep,
        output iss_vld_op, iss_rt_op, iss_data_op, iss_lat_op,
        output flush, chk_addr_a, chk_addr_b,
        input  iss_rdy_ep, iss_err_ep, iss_rdy_op, iss_err_op,
        input  chk_hit_a, chk_hit_b,
        input  rt_wr_en_ep, rt_addr_ep, rt_wr_ep,
        input  rt_wr_en_op, rt_addr_op, rt_wr_op,
        input  pend_cnt_ep, pend_cnt_op
    );

    modport slave (
        input  iss_vld_ep, iss_rt_ep, iss_data_ep, iss_lat_ep,
        input  iss_vld_op, iss_rt_op, iss_data_op, iss_lat_op,
        input  flush, chk_addr_a, chk_addr_b,
        output iss_rdy_ep, iss_err_ep, iss_rdy_op, iss_err_op,
        output chk_hit_a, chk_hit_b,
        output rt_wr_en_ep, rt_addr_ep, rt_wr_ep,
        output rt_wr_en_op, rt_addr_op, rt_wr_op,
        output pend_cnt_ep, pend_cnt_op
    );
endinterface

// File: rtl/reg_wb_ctrl.sv
// Dual-pipe result staging: results wait in a shifting slot line and write the register file from slot 0.
// Latency: an issue with latency L accepted in cycle T writes in cycle T+L-1; hazard hits appear from T+1.
// Backpressure: iss_rdy drops while the target slot is occupied, and the source holds its request until accepted.

// One pipe's slot line: shift toward slot 0 every edge, insert at slot L-2.
// Latency: slot 0 is presented combinationally; pend_cnt and iss_err are registered.
// Backpressure: iss_rdy_o is low for an illegal latency or an occupied slot L-1.
module reg_wb_pipe #(
    parameter int DEPTH = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         iss_vld_i,
    input  logic [6:0]   iss_rt_i,
    input  logic [127:0] iss_data_i,
    input  logic [2:0]   iss_lat_i,
    output logic         iss_rdy_o,
    output logic         iss_err_o,
    input  logic [6:0]   chk_addr_a_i,
    input  logic [6:0]   chk_addr_b_i,
    output logic         chk_hit_a_o,
    output logic         chk_hit_b_o,
    output logic         wr_vld_o,
    output logic [6:0]   wr_rt_o,
    output logic [127:0] wr_data_o,
    output logic [2:0]   pend_cnt_o
);
    // DEPTH is expected in 2..6: the 3-bit latency field tops out at 7 = DEPTH+1,
    // and the 3-bit occupancy count holds at most 7.
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [6:0]       rt_q   [DEPTH];
    logic [6:0]       rt_d   [DEPTH];
    logic [127:0]     data_q [DEPTH];
    logic [127:0]     data_d [DEPTH];
    logic             err_q, err_d;
    logic [2:0]       pend_q, pend_d;
    logic             lat_ok;
    logic             busy;
    logic             acc;

    // Latency legality and occupancy of the slot that will shift into L-2.
    always_comb begin
        lat_ok = (iss_lat_i >= 3'd2) && (int'(iss_lat_i) <= DEPTH + 1);
        busy   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == int'(iss_lat_i) - 1) begin
                busy = vld_q[i];
            end
        end
    end

    assign iss_rdy_o = lat_ok && !busy;
    assign acc       = iss_vld_i && iss_rdy_o && !flush_i;
    assign err_d     = iss_vld_i && !lat_ok;

    // Next slot line: shift by one, drop in the accepted issue, then apply flush.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            vld_d[i]  = vld_q[i+1];
            rt_d[i]   = rt_q[i+1];
            data_d[i] = data_q[i+1];
        end
        vld_d[DEPTH-1]  = 1'b0;
        rt_d[DEPTH-1]   = rt_q[DEPTH-1];
        data_d[DEPTH-1] = data_q[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            if (acc && (i == int'(iss_lat_i) - 2)) begin
                vld_d[i]  = 1'b1;
                rt_d[i]   = iss_rt_i;
                data_d[i] = iss_data_i;
            end
        end
        if (flush_i) begin
            vld_d = '0;
        end
        pend_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_d = pend_d + {2'b00, vld_d[i]};
        end
    end

    // Hazard lookup over every currently valid slot, slot 0 included.
    always_comb begin
        chk_hit_a_o = 1'b0;
        chk_hit_b_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (rt_q[i] == chk_addr_a_i)) chk_hit_a_o = 1'b1;
            if (vld_q[i] && (rt_q[i] == chk_addr_b_i)) chk_hit_b_o = 1'b1;
        end
    end

    // Control state: valid bits, error pulse and occupancy clear asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            err_q  <= 1'b0;
            pend_q <= '0;
        end else begin
            vld_q  <= vld_d;
            err_q  <= err_d;
            pend_q <= pend_d;
        end
    end

    // Payload carries no reset; it is only observed behind a valid bit.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            rt_q[i]   <= rt_d[i];
            data_q[i] <= data_d[i];
        end
    end

    assign wr_vld_o   = vld_q[0];
    assign wr_rt_o    = rt_q[0];
    assign wr_data_o  = data_q[0];
    assign iss_err_o  = err_q;
    assign pend_cnt_o = pend_q;
endmodule

// Top: two independent slot lines, shared hazard lookup and same-address write arbitration.
// Latency: writes leave slot 0 combinationally; hazard results are combinational on current slots.
// Backpressure: per-pipe iss_rdy; the two pipes never block each other.
module reg_wb_ctrl #(
    parameter int DEPTH = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_wb_ctrl_if.slave bus
);
    logic         ep_wr_vld, op_wr_vld;
    logic [6:0]   ep_wr_rt, op_wr_rt;
    logic [127:0] ep_wr_data, op_wr_data;
    logic         ep_hit_a, ep_hit_b, op_hit_a, op_hit_b;
    logic         ep_rdy, op_rdy, ep_err, op_err;
    logic [2:0]   ep_pend, op_pend;

    reg_wb_pipe #(.DEPTH(DEPTH)) u_ep (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (bus.flush),
        .iss_vld_i    (bus.iss_vld_ep),
        .iss_rt_i     (bus.iss_rt_ep),
        .iss_data_i   (bus.iss_data_ep),
        .iss_lat_i    (bus.iss_lat_ep),
        .iss_rdy_o    (ep_rdy),
        .iss_err_o    (ep_err),
        .chk_addr_a_i (bus.chk_addr_a),
        .chk_addr_b_i (bus.chk_addr_b),
        .chk_hit_a_o  (ep_hit_a),
        .chk_hit_b_o  (ep_hit_b),
        .wr_vld_o     (ep_wr_vld),
        .wr_rt_o      (ep_wr_rt),
        .wr_data_o    (ep_wr_data),
        .pend_cnt_o   (ep_pend)
    );

    reg_wb_pipe #(.DEPTH(DEPTH)) u_op (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (bus.flush),
        .iss_vld_i    (bus.iss_vld_op),
        .iss_rt_i     (bus.iss_rt_op),
        .iss_data_i   (bus.iss_data_op),
        .iss_lat_i    (bus.iss_lat_op),
        .iss_rdy_o    (op_rdy),
        .iss_err_o    (op_err),
        .chk_addr_a_i (bus.chk_addr_a),
        .chk_addr_b_i (bus.chk_addr_b),
        .chk_hit_a_o  (op_hit_a),
        .chk_hit_b_o  (op_hit_b),
        .wr_vld_o     (op_wr_vld),
        .wr_rt_o      (op_wr_rt),
        .wr_data_o    (op_wr_data),
        .pend_cnt_o   (op_pend)
    );

    // Same-address retire in both pipes: the odd result is the one that lands.
    always_comb begin
        bus.rt_wr_en_ep = ep_wr_vld && !(op_wr_vld && (ep_wr_rt == op_wr_rt));
        bus.rt_wr_en_op = op_wr_vld;
        bus.rt_addr_ep  = ep_wr_rt;
        bus.rt_wr_ep    = ep_wr_data;
        bus.rt_addr_op  = op_wr_rt;
        bus.rt_wr_op    = op_wr_data;
    end

    assign bus.chk_hit_a   = ep_hit_a | op_hit_a;
    assign bus.chk_hit_b   = ep_hit_b | op_hit_b;
    assign bus.iss_rdy_ep  = ep_rdy;
    assign bus.iss_rdy_op  = op_rdy;
    assign bus.iss_err_ep  = ep_err;
    assign bus.iss_err_op  = op_err;
    assign bus.pend_cnt_ep = ep_pend;
    assign bus.pend_cnt_op = op_pend;
endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed bench for reg_wb_ctrl: latency timing, backpressure, collision, errors, flush and reset.
// Latency: inputs change 1ns after posedge; outputs are sampled 1ns later, well before the next edge.
// Backpressure: rejected issues are held by the bench until accepted.
module tb_reg_wb_ctrl;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    reg_wb_ctrl_if bus ();

    reg_wb_ctrl #(.DEPTH(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] D_A5 = {16{8'hA5}};
    localparam logic [127:0] D_EE = {16{8'hEE}};

    task automatic chkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.iss_vld_ep  = 1'b0; bus.iss_rt_ep = '0; bus.iss_data_ep = '0; bus.iss_lat_ep = '0;
        bus.iss_vld_op  = 1'b0; bus.iss_rt_op = '0; bus.iss_data_op = '0; bus.iss_lat_op = '0;
        bus.flush       = 1'b0;
        bus.chk_addr_a  = '0;
        bus.chk_addr_b  = '0;

        // reset state
        #12;
        chkb("rst_wr_en_ep", bus.rt_wr_en_ep, 1'b0);
        chkb("rst_wr_en_op", bus.rt_wr_en_op, 1'b0);
        chk3("rst_pend_ep", bus.pend_cnt_ep, 3'd0);
        chk3("rst_pend_op", bus.pend_cnt_op, 3'd0);
        chkb("rst_err_ep", bus.iss_err_ep, 1'b0);
        chkb("rst_err_op", bus.iss_err_op, 1'b0);
        chkb("rst_hit_a", bus.chk_hit_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // even L=4 rt=5: write three cycles later, hazard visible from the next cycle
        bus.iss_vld_ep = 1'b1; bus.iss_rt_ep = 7'd5; bus.iss_data_ep = D_A5; bus.iss_lat_ep = 3'd4;
        bus.chk_addr_a = 7'd5;
        #1;
        chkb("l4_rdy", bus.iss_rdy_ep, 1'b1);
        chkb("l4_hit_same_cycle", bus.chk_hit_a, 1'b0);
        tick();
        bus.iss_vld_ep = 1'b0;
        #1;
        chkb("l4_hit_t1", bus.chk_hit_a, 1'b1);
        chkb("l4_wr_t1", bus.rt_wr_en_ep, 1'b0);
        chk3("l4_pend_t1", bus.pend_cnt_ep, 3'd1);
        tick();
        chkb("l4_hit_t2", bus.chk_hit_a, 1'b1);
        chkb("l4_wr_t2", bus.rt_wr_en_ep, 1'b0);
        tick();
        chkb("l4_wr_t3", bus.rt_wr_en_ep, 1'b1);
        chk7("l4_addr_t3", bus.rt_addr_ep, 7'd5);
        chkd("l4_data_t3", bus.rt_wr_ep, D_A5);
        chkb("l4_hit_t3", bus.chk_hit_a, 1'b1);
        tick();
        chkb("l4_wr_t4", bus.rt_wr_en_ep, 1'b0);
        chkb("l4_hit_t4", bus.chk_hit_a, 1'b0);
        chk3("l4_pend_t4", bus.pend_cnt_ep, 3'd0);

        // odd L=6 then L=5: second is blocked one cycle, held, then accepted
        bus.iss_vld_op = 1'b1; bus.iss_rt_op = 7'd3; bus.iss_data_op = 128'h11; bus.iss_lat_op = 3'd6;
        #1;
        chkb("bp_rdy_c0", bus.iss_rdy_op, 1'b1);
        tick();
        bus.iss_rt_op = 7'd4; bus.iss_data_op = 128'h22; bus.iss_lat_op = 3'd5;
        #1;
        chkb("bp_rdy_c1", bus.iss_rdy_op, 1'b0);
        tick();
        chkb("bp_rdy_c2", bus.iss_rdy_op, 1'b1);
        tick();
        bus.iss_vld_op = 1'b0;
        tick();
        chkb("bp_wr_c4", bus.rt_wr_en_op, 1'b0);
        tick();
        chkb("bp_wr_c5", bus.rt_wr_en_op, 1'b1);
        chk7("bp_addr_c5", bus.rt_addr_op, 7'd3);
        chkd("bp_data_c5", bus.rt_wr_op, 128'h11);
        tick();
        chkb("bp_wr_c6", bus.rt_wr_en_op, 1'b1);
        chk7("bp_addr_c6", bus.rt_addr_op, 7'd4);
        chkd("bp_data_c6", bus.rt_wr_op, 128'h22);
        tick();
        chkb("bp_wr_c7", bus.rt_wr_en_op, 1'b0);

        // both pipes retire rt=9 together: odd wins
        bus.iss_vld_ep = 1'b1; bus.iss_rt_ep = 7'd9; bus.iss_data_ep = D_EE;    bus.iss_lat_ep = 3'd3;
        bus.iss_vld_op = 1'b1; bus.iss_rt_op = 7'd9; bus.iss_data_op = 128'h0F; bus.iss_lat_op = 3'd3;
        #1;
        chkb("col_rdy_ep", bus.iss_rdy_ep, 1'b1);
        chkb("col_rdy_op", bus.iss_rdy_op, 1'b1);
        tick();
        bus.iss_vld_ep = 1'b0; bus.iss_vld_op = 1'b0;
        #1;
        chk3("col_pend_ep", bus.pend_cnt_ep, 3'd1);
        chk3("col_pend_op", bus.pend_cnt_op, 3'd1);
        tick();
        chkb("col_wr_ep", bus.rt_wr_en_ep, 1'b0);
        chkb("col_wr_op", bus.rt_wr_en_op, 1'b1);
        chk7("col_addr_op", bus.rt_addr_op, 7'd9);
        chkd("col_data_op", bus.rt_wr_op, 128'h0F);
        tick();
        chk3("col_pend_ep_end", bus.pend_cnt_ep, 3'd0);

        // minimum latency, different addresses: both write next cycle
        bus.iss_vld_ep = 1'b1; bus.iss_rt_ep = 7'd10; bus.iss_data_ep = 128'hA0; bus.iss_lat_ep = 3'd2;
        bus.iss_vld_op = 1'b1; bus.iss_rt_op = 7'd11; bus.iss_data_op = 128'hB0; bus.iss_lat_op = 3'd2;
        tick();
        bus.iss_vld_ep = 1'b0; bus.iss_vld_op = 1'b0;
        #1;
        chkb("l2_wr_ep", bus.rt_wr_en_ep, 1'b1);
        chk7("l2_addr_ep", bus.rt_addr_ep, 7'd10);
        chkb("l2_wr_op", bus.rt_wr_en_op, 1'b1);
        chk7("l2_addr_op", bus.rt_addr_op, 7'd11);
        tick();

        // maximum latency L=7: always ready, writes six cycles later
        bus.iss_vld_ep = 1'b1; bus.iss_rt_ep = 7'd12; bus.iss_data_ep = 128'h77; bus.iss_lat_ep = 3'd7;
        #1;
        chkb("l7_rdy", bus.iss_rdy_ep, 1'b1);
        tick();
        bus.iss_vld_ep = 1'b0;
        repeat (4) tick();
        chkb("l7_wr_t5", bus.rt_wr_en_ep, 1'b0);
        tick();
        chkb("l7_wr_t6", bus.rt_wr_en_ep, 1'b1);
        chk7("l7_addr_t6", bus.rt_addr_ep, 7'd12);
        chkd("l7_data_t6", bus.rt_wr_ep, 128'h77);
        tick();

        // illegal latencies: rdy low, one-cycle error pulse, nothing inserted
        bus.iss_vld_ep = 1'b1; bus.iss_rt_ep = 7'd6; bus.iss_lat_ep = 3'd1;
        #1;
        chkb("l1_rdy", bus.iss_rdy_ep, 1'b0);
        tick();
        bus.iss_vld_ep = 1'b0;
        #1;
        chkb("l1_err", bus.iss_err_ep, 1'b1);
        chkb("l1_err_op_quiet", bus.iss_err_op, 1'b0);
        chk3("l1_pend", bus.pend_cnt_ep, 3'd0);
        tick();
        chkb("l1_err_clear", bus.iss_err_ep, 1'b0);
        bus.iss_vld_op = 1'b1; bus.iss_lat_op = 3'd0;
        #1;
        chkb("l0_rdy", bus.iss_rdy_op, 1'b0);
        tick();
        bus.iss_vld_op = 1'b0;
        #1;
        chkb("l0_err", bus.iss_err_op, 1'b1);
        chk3("l0_pend", bus.pend_cnt_op, 3'd0);
        tick();
        chkb("l0_err_clear", bus.iss_err_op, 1'b0);

        // three pending, then flush with a same-cycle issue
        bus.iss_vld_ep = 1'b1; bus.iss_lat_ep = 3'd7; bus.iss_rt_ep = 7'd1;
        tick();
        bus.iss_rt_ep = 7'd2;
        tick();
        bus.iss_rt_ep = 7'd3;
        tick();
        bus.iss_vld_ep = 1'b0;
        bus.chk_addr_a = 7'd1;
        #1;
        chk3("fl_pend_before", bus.pend_cnt_ep, 3'd3);
        chkb("fl_hit_before", bus.chk_hit_a, 1'b1);
        bus.flush = 1'b1;
        bus.iss_vld_op = 1'b1; bus.iss_rt_op = 7'd20; bus.iss_lat_op = 3'd3;
        tick();
        bus.flush = 1'b0;
        bus.iss_vld_op = 1'b0;
        bus.chk_addr_b = 7'd20;
        #1;
        chk3("fl_pend_ep", bus.pend_cnt_ep, 3'd0);
        chk3("fl_pend_op", bus.pend_cnt_op, 3'd0);
        chkb("fl_hit_a", bus.chk_hit_a, 1'b0);
        chkb("fl_hit_b", bus.chk_hit_b, 1'b0);
        for (int c = 0; c < 7; c++) begin
            chkb("fl_wr_ep", bus.rt_wr_en_ep, 1'b0);
            chkb("fl_wr_op", bus.rt_wr_en_op, 1'b0);
            tick();
        end

        // reset pulse mid-stream drops everything pending
        bus.iss_vld_ep = 1'b1; bus.iss_rt_ep = 7'd7; bus.iss_data_ep = 128'h33; bus.iss_lat_ep = 3'd3;
        bus.iss_vld_op = 1'b1; bus.iss_rt_op = 7'd8; bus.iss_data_op = 128'h44; bus.iss_lat_op = 3'd6;
        tick();
        bus.iss_vld_ep = 1'b0; bus.iss_vld_op = 1'b0;
        tick();
        chkb("rs_wr_ep_before", bus.rt_wr_en_ep, 1'b1);
        chk7("rs_addr_ep_before", bus.rt_addr_ep, 7'd7);
        #1;
        rst_n = 1'b0;
        #1;
        chkb("rs_wr_ep_async", bus.rt_wr_en_ep, 1'b0);
        chkb("rs_wr_op_async", bus.rt_wr_en_op, 1'b0);
        chk3("rs_pend_op_async", bus.pend_cnt_op, 3'd0);
        bus.chk_addr_b = 7'd8;
        #1;
        chkb("rs_hit_b", bus.chk_hit_b, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chkb("rs_wr_ep_after", bus.rt_wr_en_ep, 1'b0);
            chkb("rs_wr_op_after", bus.rt_wr_en_op, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_wb_ctrl.md
REG_WB_CTRL -- requirements
Module: reg_wb_ctrl

Interface
REQ-001 Parameter: DEPTH, default 6, number of staging slots per pipe; supports latencies 2..DEPTH+1.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 iss_vld_ep / iss_vld_op  input  1 each  even/odd pipe result issue request.
REQ-005 iss_rt_ep / iss_rt_op  input  7 each  destination register address.
REQ-006 iss_data_ep / iss_data_op  input  128 each  result value.
REQ-007 iss_lat_ep / iss_lat_op  input  3 each  unit latency in cycles; legal 2..7.
REQ-008 iss_rdy_ep / iss_rdy_op  output  1 each  issue accepted this cycle if vld also high.
REQ-009 iss_err_ep / iss_err_op  output  1 each  registered one-cycle pulse for an illegal-latency issue.
REQ-010 flush  input  1  synchronous clear of all pending results.
REQ-011 chk_addr_a / chk_addr_b  input  7 each  hazard query addresses.
REQ-012 chk_hit_a / chk_hit_b  output  1 each  query address has a pending write in either pipe.
REQ-013 rt_wr_en_ep / rt_wr_en_op  output  1 each  register file write enables.
REQ-014 rt_addr_ep / rt_addr_op  output  7 each  register file write addresses.
REQ-015 rt_wr_ep / rt_wr_op  output  128 each  register file write data.
REQ-016 pend_cnt_ep / pend_cnt_op  output  3 each  number of valid slots per pipe.

Function
REQ-017 Each pipe SHALL hold DEPTH slots {valid, rt, data}; slot 0 is oldest; every posedge all slots shift one toward slot 0, and slot 0 is retired.
REQ-018 Write outputs SHALL be driven from slot 0: wr_en = slot0.valid, addr = slot0.rt, data = slot0.data; data/addr are don't-care when wr_en is low.
REQ-019 An issue accepted in cycle T with latency L SHALL be written to slot L-2 at the end of cycle T and SHALL appear on the write port in cycle T+L-1, so the register file commits at the edge ending cycle T+L-1.
REQ-020 iss_rdy SHALL be combinational: high when iss_lat is legal and slot L-1 is invalid, or when L-1 = DEPTH; otherwise low.
REQ-021 An issue SHALL be accepted only when vld, rdy and a legal latency are all high; a rejected issue SHALL leave all state unchanged, and the source holds the request.
REQ-022 iss_lat of 0, 1 or greater than DEPTH+1 with vld high SHALL set iss_err the next cycle for one cycle, without insertion; iss_rdy SHALL be low for such latencies.
REQ-023 If both pipes present slot-0 writes to the same address in the same cycle, rt_wr_en_ep SHALL be forced low and the odd write kept.
REQ-024 chk_hit SHALL be combinational: OR over all valid slots 0..DEPTH-1 of both pipes of (slot.rt == chk_addr); a slot-0 entry counts as pending.
REQ-025 A same-cycle accepted issue SHALL NOT affect chk_hit until the next cycle.
REQ-026 pend_cnt SHALL be registered and SHALL equal the count of valid slots after the current edge's update.
REQ-027 flush high at a posedge SHALL invalidate all slots in both pipes and drop any same-cycle issue; write enables SHALL be low in the following cycle.
REQ-028 Independent issues on the two pipes SHALL both be accepted in the same cycle; the pipes do not share slots.

Reset
REQ-029 While rst_n is low, all slot valid bits, iss_err, and pend_cnt SHALL be 0, and wr_en outputs SHALL be 0, asynchronously.
REQ-030 Slot data and address SHALL NOT require reset; outputs derived from them are don't-care while wr_en is 0.
REQ-031 Deassertion of rst_n SHALL take effect at the next posedge; reset asserted mid-operation SHALL discard all pending writes with no partial write.

Verification
REQ-032 Even issue rt=5, data=0xA5.., L=4 in cycle 10 -> rt_wr_en_ep=1, addr 5, data 0xA5.. in cycle 13 only; chk_hit(5)=1 in cycles 11..13, 0 in cycle 14.
REQ-033 Odd issue L=6 in cycle 0, then odd issue L=5 in cycle 1 -> iss_rdy_op=0 in cycle 1; the source holds, is accepted in cycle 2, and the two writes occur in cycles 5 and 6.
REQ-034 Both pipes write rt=9 in the same retire cycle -> rt_wr_en_ep=0, rt_wr_en_op=1 with the odd data.
REQ-035 Issue L=1 on even with vld high -> iss_rdy_ep=0; iss_err_ep=1 for one cycle next; pend_cnt_ep unchanged.
REQ-036 Three pending writes, then flush in cycle 20 with an issue in the same cycle -> no writes from cycle 21; pend_cnt=0; chk_hit=0.
REQ-037 rst_n pulsed low mid-stream -> wr_en outputs immediately 0; no write of pre-reset entries after release.
